sevenseg_scan: RTL and testbench

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

---
 rtl/sevenseg_scan_pkg.sv | 26 ++
 rtl/sevenseg_scan_bcd.sv | 33 +++
 rtl/sevenseg_scan.sv | 114 +++++++++++
 tb/tb_sevenseg_scan.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_scan_pkg.sv
// ============================================================================
// Module  : sevenseg_scan_pkg
// Brief   : Shared display constants and types for the four-digit scanner.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sevenseg_scan_pkg;

    localparam int          c_slot_count = 4;
    localparam logic [6:0]  c_seg_off    = 7'b1111111;
    localparam logic [3:0]  c_an_off     = 4'b1111;

    typedef enum logic [0:0] {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_t;

    // Active-low one-hot anode pattern for a slot index.
    function automatic logic [3:0] anode_onehot_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_scan_bcd.sv
// ============================================================================
// Module  : sevenseg_scan_bcd
// Brief   : BCD to active-low seven-segment decoder, seg_n = {g,f,e,d,c,b,a}.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sevenseg_scan_bcd
    import sevenseg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        case (bcd)
            4'd0:    seg_n = 7'b1000000;
            4'd1:    seg_n = 7'b1111001;
            4'd2:    seg_n = 7'b0100100;
            4'd3:    seg_n = 7'b0110000;
            4'd4:    seg_n = 7'b0011001;
            4'd5:    seg_n = 7'b0010010;
            4'd6:    seg_n = 7'b0000010;
            4'd7:    seg_n = 7'b1111000;
            4'd8:    seg_n = 7'b0000000;
            4'd9:    seg_n = 7'b0010000;
            default: seg_n = c_seg_off;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan.sv
// ============================================================================
// Module  : sevenseg_scan
// Brief   : Four-digit multiplexed seven-segment scanner with double-buffered
//           load, anti-ghost blanking and leading-zero suppression.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sevenseg_scan
    import sevenseg_scan_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        load,
    output logic        ready,
    input  logic        lzb,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        active_q, active_d;
    logic [15:0]        pending_q, pending_d;
    logic               ready_q, ready_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    logic               w_slot_wrap;
    logic               w_frame_boundary;
    logic               w_load_accept;
    slot_state_t        w_state;
    logic [3:0]         w_nibble;
    logic [6:0]         w_dec_seg;
    logic               w_upper_zero;
    logic               w_lz_blank;

    assign w_slot_wrap      = (cnt_q == c_cnt_w'(DIV - 1));
    assign w_frame_boundary = w_slot_wrap && (idx_q == 2'(c_slot_count - 1));
    assign w_load_accept    = load && ready_q;
    assign w_state          = (cnt_q < c_cnt_w'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_DRIVE;
    assign w_nibble         = active_q[{idx_q, 2'b00} +: 4];

    // A digit is a leading zero when it and every nibble above it are zero.
    assign w_upper_zero     = ((active_q >> {idx_q, 2'b00}) == 16'h0000);
    assign w_lz_blank       = lzb && (idx_q != 2'd0) && w_upper_zero;

    sevenseg_scan_bcd u_bcd (
        .bcd   (w_nibble),
        .seg_n (w_dec_seg)
    );

    always_comb begin
        cnt_d     = w_slot_wrap ? '0 : cnt_q + 1'b1;
        idx_d     = w_slot_wrap ? idx_q + 2'd1 : idx_q;
        active_d  = active_q;
        pending_d = pending_q;
        ready_d   = ready_q;

        // Active only ever changes on the frame boundary, so no frame mixes values.
        if (w_load_accept) begin
            if (w_frame_boundary) begin
                active_d = din;
            end else begin
                pending_d = din;
                ready_d   = 1'b0;
            end
        end else if (w_frame_boundary && !ready_q) begin
            active_d = pending_q;
            ready_d  = 1'b1;
        end

        if (w_state == SLOT_BLANK) begin
            an_d  = c_an_off;
            seg_d = c_seg_off;
        end else begin
            an_d  = anode_onehot_n(idx_q);
            seg_d = w_lz_blank ? c_seg_off : w_dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            active_q  <= 16'h0000;
            pending_q <= 16'h0000;
            ready_q   <= 1'b1;
            seg_q     <= c_seg_off;
            an_q      <= c_an_off;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign ready = ready_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
// ============================================================================
// Module  : tb_sevenseg_scan
// Brief   : Self-checking bench for sevenseg_scan with a position-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sevenseg_scan;

    localparam int DIV          = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        load;
    logic        ready;
    logic        lzb;
    logic [6:0]  seg;
    logic [3:0]  an;

    always #5 clk = ~clk;

    sevenseg_scan #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .load  (load),
        .ready (ready),
        .lzb   (lzb),
        .seg   (seg),
        .an    (an)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: m_p counts clock edges since reset release.
    int          m_p;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    logic        m_ready;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;

    function automatic logic [6:0] bcd_seg(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t, pos=%0d)", name, act, exp, $time, m_p);
        end
    endtask

    task automatic model_reset();
        m_p       = 0;
        m_active  = 16'h0000;
        m_pending = 16'h0000;
        m_ready   = 1'b1;
        exp_seg   = 7'h7F;
        exp_an    = 4'hF;
    endtask

    // Outputs after an edge reflect the scan position just before it.
    task automatic model_edge();
        int cnt;
        int idx;
        bit boundary;
        cnt = m_p % DIV;
        idx = (m_p / DIV) % 4;
        if (cnt < BLANK_CYCLES) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            exp_an = ~(4'b0001 << idx);
            if (lzb && idx > 0 && (m_active >> (4 * idx)) == 16'h0000)
                exp_seg = 7'h7F;
            else
                exp_seg = bcd_seg(int'((m_active >> (4 * idx)) & 16'h000F));
        end
        boundary = ((m_p % FRAME) == FRAME - 1);
        if (load && m_ready) begin
            if (boundary) m_active = din;
            else begin
                m_pending = din;
                m_ready   = 1'b0;
            end
        end else if (boundary && !m_ready) begin
            m_active = m_pending;
            m_ready  = 1'b1;
        end
        m_p++;
    endtask

    task automatic compare_outputs();
        check("seg", {9'd0, seg}, {9'd0, exp_seg});
        check("an", {12'd0, an}, {12'd0, exp_an});
        check("ready", {15'd0, ready}, {15'd0, m_ready});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    // Step until the outputs reflect scan position pos.
    task automatic goto_pos(input int pos);
        for (int i = 0; i < 10000 && (m_p - 1) < pos; i++) step();
    endtask

    task automatic pin(input string name, input logic [6:0] s, input logic [3:0] a);
        check({name, "_seg"}, {9'd0, seg}, {9'd0, s});
        check({name, "_an"}, {12'd0, an}, {12'd0, a});
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        lzb  = 1'b0;
        din  = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        pin("reset", 7'h7F, 4'hF);
        check("reset_ready", {15'd0, ready}, 16'd1);
        rst = 1'b0;

        // Two blanking edges, then digit 0 showing zero.
        step();
        step();
        pin("blank_after_release", 7'h7F, 4'hF);
        step();
        pin("first_drive", 7'b1000000, 4'b1110);

        // Mid-frame load waits for the frame boundary.
        goto_pos(9);
        load = 1'b1;
        din  = 16'h1234;
        step();
        load = 1'b0;
        check("ready_low_after_load", {15'd0, ready}, 16'd0);
        goto_pos(29);
        pin("old_frame_slot3", 7'b1000000, 4'b0111);
        goto_pos(31);
        check("ready_after_boundary", {15'd0, ready}, 16'd1);
        goto_pos(FRAME + 3);
        pin("h1234_slot0", 7'b0011001, 4'b1110);
        goto_pos(FRAME + 29);
        pin("h1234_slot3", 7'b1111001, 4'b0111);

        // Leading-zero blanking of 0070.
        lzb  = 1'b1;
        load = 1'b1;
        din  = 16'h0070;
        step();
        load = 1'b0;
        goto_pos(2 * FRAME + 2);
        pin("lz_slot0", 7'b1000000, 4'b1110);
        goto_pos(2 * FRAME + 10);
        pin("lz_slot1", 7'b1111000, 4'b1101);
        goto_pos(2 * FRAME + 18);
        pin("lz_slot2", 7'h7F, 4'b1011);
        goto_pos(2 * FRAME + 26);
        pin("lz_slot3", 7'h7F, 4'b0111);

        // Second load while busy is ignored; non-BCD nibble decodes blank.
        goto_pos(3 * FRAME + 3);
        load = 1'b1;
        din  = 16'h00A5;
        step();
        din = 16'h9999;
        repeat (5) step();
        load = 1'b0;
        check("ready_busy", {15'd0, ready}, 16'd0);
        goto_pos(4 * FRAME - 1);
        check("ready_commit_a5", {15'd0, ready}, 16'd1);
        goto_pos(4 * FRAME + 2);
        pin("a5_slot0", 7'b0010010, 4'b1110);
        goto_pos(4 * FRAME + 10);
        pin("a5_slot1", 7'h7F, 4'b1101);

        // Load landing exactly on the frame boundary commits directly.
        goto_pos(5 * FRAME - 2);
        load = 1'b1;
        din  = 16'h4321;
        step();
        load = 1'b0;
        check("ready_boundary_load", {15'd0, ready}, 16'd1);
        goto_pos(5 * FRAME + 2);
        pin("h4321_slot0", 7'b1111001, 4'b1110);
        goto_pos(5 * FRAME + 26);
        pin("h4321_slot3", 7'b0011001, 4'b0111);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] v;
            load = ($urandom % 6 == 0);
            for (int k = 0; k < 4; k++)
                v[4*k +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom % 16);
            din = v;
            if ($urandom % 50 == 0) lzb = ~lzb;
            step();
        end
        load = 1'b0;

        // Asynchronous reset during DRIVE with a load possibly pending.
        lzb  = 1'b0;
        load = 1'b1;
        din  = 16'h5555;
        step();
        load = 1'b0;
        for (int i = 0; i < 2 * DIV && an == 4'hF; i++) step();
        check("drive_before_reset", {15'd0, (an != 4'hF)}, 16'd1);
        #2 rst = 1'b1;
        #1;
        pin("async_reset", 7'h7F, 4'hF);
        check("async_reset_ready", {15'd0, ready}, 16'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
        rst = 1'b0;
        goto_pos(2);
        pin("post_reset_slot0", 7'b1000000, 4'b1110);
        goto_pos(FRAME + 2);
        pin("pending_discarded", 7'b1000000, 4'b1110);
        check("post_reset_ready", {15'd0, ready}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
